// File: rtl/simd_dot_accum.sv
// rtl/simd_dot_accum.sv - signed SIMD dot-product reduction tree with group accumulator
//
// Purpose: each accepted vector of LANES signed lanes is summed by a registered
// binary adder tree, and the tree sums are accumulated until a vector tagged
// in_last closes the group. The group result and its vector count are then
// presented on a valid/ready result handshake.
//
// Ports:
//   clk        - single clock, all registers update on its rising edge
//   rst_n      - asynchronous active-low reset
//   in_data    - LANES x LANE_W signed lanes, lane i at [LANE_W*(i+1)-1 : LANE_W*i]
//   in_valid   - in_data is valid this cycle
//   in_last    - this vector closes the current dot product
//   in_ready   - block accepts a vector this cycle
//   out_data   - completed dot-product sum (signed, wraps modulo 2^ACC_W)
//   out_count  - number of vectors in the group (saturates at 65535)
//   out_valid  - result valid
//   out_ready  - downstream accepts the result
//
// LANES must be a power of two, at least 2; ACC_W must exceed LANE_W+log2(LANES).
module simd_dot_accum #(
    parameter int LANES  = 32,
    parameter int LANE_W = 16,
    parameter int ACC_W  = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [15:0]             out_count,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int LVL = $clog2(LANES);
    localparam int TW  = LANE_W + LVL;

    logic                    en;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic [15:0]             cnt_d, cnt_q;
    logic signed [ACC_W-1:0] out_data_d, out_data_q;
    logic [15:0]             out_count_d, out_count_q;
    logic                    out_valid_d, out_valid_q;

    // A held result that downstream has not taken freezes the whole pipe,
    // so nothing can overwrite it.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    // Level k holds LANES>>k partial sums, each one bit wider than its inputs.
    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int N = LANES >> k;
        localparam int W = LANE_W + k;

        logic signed [W-2:0] src [2*N];
        logic                src_vld;
        logic                src_lst;
        logic signed [W-1:0] sum_d [N];
        logic signed [W-1:0] sum_q [N];
        logic                vld_d, vld_q;
        logic                lst_d, lst_q;

        if (k == 1) begin : g_in
            for (genvar j = 0; j < 2*N; j++) begin : g_lane
                assign src[j] = in_data[LANE_W*j +: LANE_W];
            end
            assign src_vld = in_valid;
            // A last tag on a bubble means nothing, so drop it here.
            assign src_lst = in_valid && in_last;
        end else begin : g_prev
            for (genvar j = 0; j < 2*N; j++) begin : g_lane
                assign src[j] = g_lvl[k-1].sum_q[j];
            end
            assign src_vld = g_lvl[k-1].vld_q;
            assign src_lst = g_lvl[k-1].lst_q;
        end

        always_comb begin
            for (int i = 0; i < N; i++) begin
                sum_d[i] = sum_q[i];
                if (en) begin
                    sum_d[i] = {src[2*i][W-2], src[2*i]} + {src[2*i+1][W-2], src[2*i+1]};
                end
            end
            vld_d = en ? src_vld : vld_q;
            lst_d = en ? src_lst : lst_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    sum_q[i] <= '0;
                end
                vld_q <= 1'b0;
                lst_q <= 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    sum_q[i] <= sum_d[i];
                end
                vld_q <= vld_d;
                lst_q <= lst_d;
            end
        end
    end

    logic signed [TW-1:0]    tree_sum;
    logic                    tree_vld;
    logic                    tree_lst;
    logic signed [ACC_W-1:0] tree_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic [15:0]             cnt_inc;

    assign tree_sum = g_lvl[LVL].sum_q[0];
    assign tree_vld = g_lvl[LVL].vld_q;
    assign tree_lst = g_lvl[LVL].lst_q;
    assign tree_ext = {{(ACC_W-TW){tree_sum[TW-1]}}, tree_sum};
    assign acc_sum  = acc_q + tree_ext;
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (en && tree_vld) begin
            if (tree_lst) begin
                // Closing vector: publish the group and start the next one
                // from zero on the same edge, so back-to-back groups need no gap.
                out_data_d  = acc_sum;
                out_count_d = cnt_inc;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;
endmodule
